// File: rtl/led_debug_display.sv
`default_nettype none
// ============================================================================
//  Module   : led_debug_display
//  Brief    : LED debug front-end. Snapshots a debug word and shows it on a
//             bank of data LEDs as group-OR, scrolling or frozen pages, or a
//             lamp test. Also drives a heartbeat LED and an error LED with a
//             sticky, blinking bus-error latch.
//  Revision : 1.0 - initial release
// ============================================================================
module led_debug_display #(
    parameter int DATA_W     = 32,
    parameter int LED_W      = 8,
    parameter int HB_TICKS   = 25_000_000,
    parameter int PAGE_TICKS = 50_000_000,
    localparam int c_PAGE_W  = ((DATA_W / LED_W) > 1) ? $clog2(DATA_W / LED_W) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [1:0]          mode,
    input  logic                err_in,
    input  logic                err_clr,
    output logic [LED_W+1:0]    led,
    output logic [c_PAGE_W-1:0] page
);

    localparam int c_PAGES = DATA_W / LED_W;
    localparam int c_GRP   = c_PAGES;
    localparam int c_HB_W  = $clog2(HB_TICKS);
    localparam int c_PT_W  = $clog2(PAGE_TICKS);

    localparam logic [1:0] c_MODE_OR     = 2'd0;
    localparam logic [1:0] c_MODE_SCROLL = 2'd1;
    localparam logic [1:0] c_MODE_FREEZE = 2'd2;
    localparam logic [1:0] c_MODE_LAMP   = 2'd3;

    localparam logic [c_HB_W-1:0]   c_HB_LAST = c_HB_W'(HB_TICKS - 1);
    localparam logic [c_HB_W-1:0]   c_HB_ONE  = c_HB_W'(1);
    localparam logic [c_PT_W-1:0]   c_PT_LAST = c_PT_W'(PAGE_TICKS - 1);
    localparam logic [c_PT_W-1:0]   c_PT_ONE  = c_PT_W'(1);

    logic [DATA_W-1:0]   r_snap;
    logic [1:0]          r_mode_q;
    logic [c_PT_W-1:0]   r_ptick;
    logic [c_PAGE_W-1:0] r_page;
    logic [c_HB_W-1:0]   r_htick;
    logic                r_hb;
    logic                r_err_q;
    logic                r_err_st;
    logic [LED_W+1:0]    r_led;

    logic                w_page_mode;
    logic                w_mode_chg;
    logic                w_pt_wrap;
    logic [c_PAGE_W-1:0] w_page_nxt;
    logic [LED_W-1:0]    w_grp;
    logic [LED_W-1:0]    w_sel;
    logic [LED_W-1:0]    w_data;
    logic                w_lamp;
    logic                w_hb_led;
    logic                w_err_led;
    logic                w_err_rise;

    assign w_page_mode = (mode == c_MODE_SCROLL) || (mode == c_MODE_FREEZE);
    assign w_mode_chg  = (mode != r_mode_q);
    assign w_pt_wrap   = w_page_mode && !w_mode_chg && (r_ptick == c_PT_LAST);
    assign w_lamp      = (mode == c_MODE_LAMP);
    assign w_err_rise  = err_in && !r_err_q;

    // Snapshot follows the core every cycle except while frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else if (mode != c_MODE_FREEZE) begin
            r_snap <= data_in;
        end
    end

    // Previous mode, used to detect any mode change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_q <= c_MODE_OR;
        end else begin
            r_mode_q <= mode;
        end
    end

    // Page dwell counter: runs only in page modes, restarts on mode change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptick <= '0;
        end else if (w_mode_chg || !w_page_mode || (r_ptick == c_PT_LAST)) begin
            r_ptick <= '0;
        end else begin
            r_ptick <= r_ptick + c_PT_ONE;
        end
    end

    generate
        if (c_PAGES > 1) begin : g_multi_page
            localparam logic [c_PAGE_W-1:0] c_PAGE_LAST = c_PAGE_W'(c_PAGES - 1);
            localparam logic [c_PAGE_W-1:0] c_PAGE_ONE  = c_PAGE_W'(1);
            logic [LED_W-1:0] w_pages [c_PAGES];

            // Next page index; LEDs index with it so led and page stay aligned
            always_comb begin
                w_page_nxt = r_page;
                if (w_mode_chg || !w_page_mode) begin
                    w_page_nxt = '0;
                end else if (w_pt_wrap) begin
                    w_page_nxt = (r_page == c_PAGE_LAST) ? '0 : r_page + c_PAGE_ONE;
                end
            end

            for (genvar p = 0; p < c_PAGES; p++) begin : g_page_slice
                assign w_pages[p] = r_snap[p*LED_W +: LED_W];
            end

            assign w_sel = w_pages[w_page_nxt];
        end else begin : g_single_page
            assign w_page_nxt = '0;
            assign w_sel      = r_snap[LED_W-1:0];
        end
    endgenerate

    // Displayed page index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_page <= '0;
        end else begin
            r_page <= w_page_nxt;
        end
    end

    generate
        for (genvar i = 0; i < LED_W; i++) begin : g_group_or
            assign w_grp[i] = |r_snap[i*c_GRP +: c_GRP];
        end
    endgenerate

    // Data LED source selection by display mode
    always_comb begin
        w_data = '0;
        case (mode)
            c_MODE_OR:     w_data = w_grp;
            c_MODE_SCROLL: w_data = w_sel;
            c_MODE_FREEZE: w_data = w_sel;
            default:       w_data = '1;
        endcase
    end

    // Free-running heartbeat: hb toggles once per HB_TICKS cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_htick <= '0;
            r_hb    <= 1'b0;
        end else if (r_htick == c_HB_LAST) begin
            r_htick <= '0;
            r_hb    <= ~r_hb;
        end else begin
            r_htick <= r_htick + c_HB_ONE;
        end
    end

    // Sticky error: set on err_in rising edge, cleared by err_clr, set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_q  <= 1'b0;
            r_err_st <= 1'b0;
        end else begin
            r_err_q <= err_in;
            if (w_err_rise) begin
                r_err_st <= 1'b1;
            end else if (err_clr) begin
                r_err_st <= 1'b0;
            end
        end
    end

    assign w_hb_led  = w_lamp || r_hb;
    assign w_err_led = w_lamp || err_in || (r_err_st && r_hb);

    // Registered LED outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else begin
            r_led <= {w_err_led, w_hb_led, w_data};
        end
    end

    assign led  = r_led;
    assign page = r_page;

endmodule
`default_nettype wire
